// File: rtl/sad_pkg.sv
// Shared constants and types for the SAD minimum search block.
// Contents: array geometry (NDATA_IN, NCOL, NCAND), datapath widths,
// the search FSM state type and the SAD value type.
package sad_pkg;

  localparam int unsigned NDATA_IN = 100;
  localparam int unsigned NCOL     = 16;
  localparam int unsigned NCAND    = 32;
  localparam int unsigned COL_W    = $clog2(128) + 1;
  localparam int unsigned SAD_W    = COL_W + $clog2(NCOL);
  localparam int unsigned IDX_W    = $clog2(NCAND);
  localparam int unsigned CNT_W    = $clog2(NCOL);
  localparam int unsigned PRUNE_W  = IDX_W + 1;

  typedef enum logic [1:0] {
    StIdle,
    StAcc,
    StCmp,
    StDone
  } sad_state_t;

  typedef logic [SAD_W-1:0] sad_t;

endpackage

// File: rtl/sad_min_search_if.sv
// Handshake bundle between the column adder / decision logic and the SAD
// minimum search block.
//   master: drives start, in_valid, col_sum, out_ready
//   slave : drives in_ready, out_valid, best_sad, best_idx, busy
// Optional macro SAD_EARLY_EXIT_EN adds prune_cnt (slave output).
interface sad_min_search_if;
  import sad_pkg::*;

  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic [COL_W-1:0] col_sum;
  logic             out_valid;
  logic             out_ready;
  sad_t             best_sad;
  logic [IDX_W-1:0] best_idx;
  logic             busy;
`ifdef SAD_EARLY_EXIT_EN
  logic [PRUNE_W-1:0] prune_cnt;

  modport master (
    output start, in_valid, col_sum, out_ready,
    input  in_ready, out_valid, best_sad, best_idx, busy, prune_cnt
  );

  modport slave (
    input  start, in_valid, col_sum, out_ready,
    output in_ready, out_valid, best_sad, best_idx, busy, prune_cnt
  );
`else
  modport master (
    output start, in_valid, col_sum, out_ready,
    input  in_ready, out_valid, best_sad, best_idx, busy
  );

  modport slave (
    input  start, in_valid, col_sum, out_ready,
    output in_ready, out_valid, best_sad, best_idx, busy
  );
`endif

endinterface

// File: rtl/sad_col_acc.sv
// Per-candidate column accumulator.
// Ports:
//   clk, rst   clock, async active-high reset
//   clear      zero accumulator and column counter (search start / compare)
//   xfer       a column sum is being accepted this cycle
//   add_en     add the accepted column (low = column consumed but ignored)
//   col_sum    column sum, zero-extended into the accumulator
//   acc        running SAD of the current candidate
//   last_col   the column counter points at the final column of the block
module sad_col_acc
  import sad_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             xfer,
  input  logic             add_en,
  input  logic [COL_W-1:0] col_sum,
  output sad_t             acc,
  output logic             last_col
);

  sad_t             acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign last_col = (cnt_q == CNT_W'(NCOL - 1));
  assign acc      = acc_q;

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clear) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (xfer) begin
      if (add_en) begin
        acc_d = acc_q + sad_t'(col_sum);
      end
      cnt_d = last_col ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sad_min_search.sv
// SAD minimum search: accumulates NCOL column sums per candidate over NCAND
// candidates and reports the smallest SAD and the index that produced it.
// Ports:
//   clk, rst   clock, async active-high reset
//   bus        sad_min_search_if.slave (start, column input handshake,
//              result handshake, best_sad, best_idx, busy)
// Optional macro SAD_EARLY_EXIT_EN: stop adding columns once a candidate
// can no longer win, and count such candidates on bus.prune_cnt.
module sad_min_search
  import sad_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  sad_min_search_if.slave  bus
);

  sad_state_t       state_q, state_d;
  sad_t             best_sad_q, best_sad_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic [IDX_W-1:0] cand_q, cand_d;

  logic xfer;
  logic acc_clear;
  logic add_en;
  logic last_col;
  sad_t acc;

`ifdef SAD_EARLY_EXIT_EN
  logic [PRUNE_W-1:0] prune_q, prune_d;
  logic               pruned;

  // Candidate 0 always seeds best_sad; later ones lose once acc reaches it.
  assign pruned    = (cand_q != '0) && (acc >= best_sad_q);
  assign add_en    = !pruned;
  assign bus.prune_cnt = prune_q;
`else
  assign add_en = 1'b1;
`endif

  sad_col_acc u_col_acc (
    .clk      (clk),
    .rst      (rst),
    .clear    (acc_clear),
    .xfer     (xfer),
    .add_en   (add_en),
    .col_sum  (bus.col_sum),
    .acc      (acc),
    .last_col (last_col)
  );

  always_comb begin
    state_d    = state_q;
    best_sad_d = best_sad_q;
    best_idx_d = best_idx_q;
    cand_d     = cand_q;
    xfer       = 1'b0;
    acc_clear  = 1'b0;
`ifdef SAD_EARLY_EXIT_EN
    prune_d    = prune_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d    = StAcc;
          best_sad_d = '1;
          best_idx_d = '0;
          cand_d     = '0;
          acc_clear  = 1'b1;
`ifdef SAD_EARLY_EXIT_EN
          prune_d    = '0;
`endif
        end
      end
      StAcc: begin
        xfer = bus.in_valid;
        if (xfer && last_col) begin
          state_d = StCmp;
        end
      end
      StCmp: begin
        // Strict compare: on a tie the earlier candidate is kept.
        if (acc < best_sad_q) begin
          best_sad_d = acc;
          best_idx_d = cand_q;
        end
`ifdef SAD_EARLY_EXIT_EN
        if (pruned) begin
          prune_d = prune_q + 1'b1;
        end
`endif
        acc_clear = 1'b1;
        if (cand_q == IDX_W'(NCAND - 1)) begin
          state_d = StDone;
        end else begin
          cand_d  = cand_q + 1'b1;
          state_d = StAcc;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      best_sad_q <= '1;
      best_idx_q <= '0;
      cand_q     <= '0;
`ifdef SAD_EARLY_EXIT_EN
      prune_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      best_sad_q <= best_sad_d;
      best_idx_q <= best_idx_d;
      cand_q     <= cand_d;
`ifdef SAD_EARLY_EXIT_EN
      prune_q    <= prune_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == StAcc);
  assign bus.out_valid = (state_q == StDone);
  assign bus.busy      = (state_q != StIdle);
  assign bus.best_sad  = best_sad_q;
  assign bus.best_idx  = best_idx_q;

endmodule

// File: tb/tb_sad_min_search.sv
// Self-checking bench for sad_min_search: table-driven directed searches,
// a mid-search reset sequence and randomized searches checked against a
// plain-arithmetic reference model.
module tb_sad_min_search;
  import sad_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sad_min_search_if bus ();

  sad_min_search dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cols [NCAND][NCOL];

  localparam int ALL_ONES = (1 << SAD_W) - 1;

  typedef struct {
    string name;
    int    base;
    int    ca;
    int    va;
    int    cb;
    int    vb;
    int    exp_sad;
    int    exp_idx;
    bit    gaps;
    bit    hold;
    bit    mid_start;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void fill(input int base, input int ca, input int va,
                               input int cb, input int vb);
    for (int c = 0; c < int'(NCAND); c++) begin
      for (int k = 0; k < int'(NCOL); k++) begin
        cols[c][k] = (c == ca) ? va : (c == cb) ? vb : base;
      end
    end
  endfunction

  // Reference: full sums, lowest index of the strict minimum, and the number
  // of candidates (after the first) whose sum does not beat the running best.
  function automatic void model(output int sad, output int idx, output int prunes);
    int sums [NCAND];
    int run_min;
    for (int c = 0; c < int'(NCAND); c++) begin
      sums[c] = 0;
      for (int k = 0; k < int'(NCOL); k++) sums[c] += cols[c][k];
    end
    sad = sums[0];
    idx = 0;
    prunes = 0;
    run_min = sums[0];
    for (int c = 1; c < int'(NCAND); c++) begin
      if (sums[c] >= run_min) prunes++;
      if (sums[c] < sad) begin
        sad = sums[c];
        idx = c;
      end
      if (sums[c] < run_min) run_min = sums[c];
    end
  endfunction

  task automatic send_col(input int v, output bit ok);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.col_sum  = COL_W'(v);
    while (!bus.in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    ok = bus.in_ready;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic run_search(input string tag, input int exp_sad, input int exp_idx,
                            input bit gaps, input bit hold, input bit mid_start);
    int m_sad, m_idx, m_pr;
    bit ok;
    bit stable;
    int n;
    model(m_sad, m_idx, m_pr);
    pulse_start();
    check({tag, " busy after start"}, int'(bus.busy), 1);
    for (int c = 0; c < int'(NCAND); c++) begin
      for (int k = 0; k < int'(NCOL); k++) begin
        if (gaps) begin
          bus.in_valid = 1'b0;
          @(posedge clk);
          #1;
        end
        if (mid_start && c == 10 && k == 0) pulse_start();
        send_col(cols[c][k], ok);
        if (!ok) begin
          check({tag, " in_ready timeout"}, 0, 1);
          return;
        end
      end
    end
    check({tag, " out_valid low in compare cycle"}, int'(bus.out_valid), 0);
    @(posedge clk);
    #1;
    check({tag, " out_valid two cycles after last column"}, int'(bus.out_valid), 1);
    check({tag, " best_sad"}, int'(bus.best_sad), exp_sad);
    check({tag, " best_idx"}, int'(bus.best_idx), exp_idx);
`ifdef SAD_EARLY_EXIT_EN
    check({tag, " prune_cnt"}, int'(bus.prune_cnt), m_pr);
`endif
    if (hold) begin
      stable = 1'b1;
      bus.in_valid = 1'b1;
      bus.col_sum  = COL_W'(7);
      for (int i = 0; i < 10; i++) begin
        bus.start = (i == 3);
        @(posedge clk);
        #1;
        if (!bus.out_valid || bus.in_ready || int'(bus.best_sad) != exp_sad ||
            int'(bus.best_idx) != exp_idx) stable = 1'b0;
      end
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      check({tag, " result held under out_ready=0"}, int'(stable), 1);
    end
    bus.out_ready = 1'b1;
    n = 0;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, " out_valid after accept"}, int'(bus.out_valid), 0);
    check({tag, " busy after accept"}, int'(bus.busy), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int r_sad, r_idx, r_pr;

    tbl[0] = '{"min_at_7",     5,  7,  2, -1, 0,   32,  7, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{"tie_3_9",      1,  3,  0,  9, 0,    0,  3, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{"backpressure", 20, 12, 19, -1, 0,  304, 12, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{"max_value",    100, -1, 0, -1, 0, 1600,  0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{"last_idx",     50, 31, 49, -1, 0,  784, 31, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{"prune_all",    100, 0,  1, -1, 0,   16,  0, 1'b0, 1'b0, 1'b0};

    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.col_sum   = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", int'(bus.in_ready), 0);
    check("reset out_valid", int'(bus.out_valid), 0);
    check("reset busy", int'(bus.busy), 0);
    check("reset best_sad", int'(bus.best_sad), ALL_ONES);
    check("reset best_idx", int'(bus.best_idx), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle busy", int'(bus.busy), 0);

    for (int i = 0; i < 6; i++) begin
      fill(tbl[i].base, tbl[i].ca, tbl[i].va, tbl[i].cb, tbl[i].vb);
      run_search(tbl[i].name, tbl[i].exp_sad, tbl[i].exp_idx,
                 tbl[i].gaps, tbl[i].hold, tbl[i].mid_start);
    end

    // Reset in the middle of candidate 4, column 8.
    fill(9, 2, 3, -1, 0);
    pulse_start();
    for (int c = 0; c < 5; c++) begin
      for (int k = 0; k < int'(NCOL); k++) begin
        if (c < 4 || k < 8) send_col(cols[c][k], ok);
      end
    end
    rst = 1'b1;
    #1;
    check("mid reset busy immediate", int'(bus.busy), 0);
    check("mid reset best_sad immediate", int'(bus.best_sad), ALL_ONES);
    @(posedge clk);
    #1;
    check("mid reset out_valid", int'(bus.out_valid), 0);
    check("mid reset busy", int'(bus.busy), 0);
    check("mid reset best_sad", int'(bus.best_sad), ALL_ONES);
    check("mid reset best_idx", int'(bus.best_idx), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    fill(tbl[0].base, tbl[0].ca, tbl[0].va, tbl[0].cb, tbl[0].vb);
    run_search("fresh_after_reset", tbl[0].exp_sad, tbl[0].exp_idx, 1'b0, 1'b0, 1'b0);

    // Randomized searches; small-range runs provoke ties.
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < int'(NCAND); c++) begin
        for (int k = 0; k < int'(NCOL); k++) begin
          cols[c][k] = int'($urandom_range(0, (r < 2) ? NDATA_IN : 2));
        end
      end
      model(r_sad, r_idx, r_pr);
      run_search($sformatf("random_%0d", r), r_sad, r_idx, r[0], 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
